// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single UART 8N1 transmitter.
// One requester is granted per frame; txd idles high and is registered.
module uart_tx_arbiter #(
    parameter int unsigned BAUD_DIV  = 10416,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        txd,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        frame_done
);

    localparam int unsigned   CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_stop_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_ptr;
    logic          r_txd;
    logic          r_busy;
    logic [1:0]    r_grant;

    logic          w_found;
    logic [1:0]    w_win;
    logic [1:0]    w_idx;
    logic          w_bit_end;
    logic          w_last_stop;

    // Search starts at the pointer so the most recent winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_last_stop = (r_stop_idx == STOP_LAST);

    assign req_ready  = (rst_n && r_state == S_IDLE && w_found) ? (4'b0001 << w_win) : '0;
    assign frame_done = (r_state == S_STOP) && w_bit_end && w_last_stop;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign grant_id   = r_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_grant    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_found) begin
                        r_shift <= req_data[{w_win, 3'b000} +: 8];
                        r_grant <= w_win;
                        r_ptr   <= w_win + 2'd1;
                        r_cnt   <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= S_STOP;
                        end else begin
                            // txd takes bit 1 because the shift lands on the same edge.
                            r_txd   <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: round-robin model plus serial line
// expectations computed from bit position arithmetic.
module tb_uart_tx_arbiter;

    localparam int unsigned B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  v1 = '0, v2 = '0;
    logic [31:0] d1 = '0, d2 = '0;
    logic [3:0]  rdy1, rdy2;
    logic        txd1, txd2, busy1, busy2, fd1, fd2;
    logic [1:0]  gid1, gid2;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [1:0]  mptr1 = '0;

    logic [9:0]  mon_q[$];
    int          mk = 0;
    logic        mon_on = 1'b0;
    logic [9:0]  mbits = '0;

    uart_tx_arbiter #(.BAUD_DIV(B), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_data(d1), .req_ready(rdy1),
        .txd(txd1), .busy(busy1), .grant_id(gid1), .frame_done(fd1)
    );

    uart_tx_arbiter #(.BAUD_DIV(B), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_data(d2), .req_ready(rdy2),
        .txd(txd2), .busy(busy2), .grant_id(gid2), .frame_done(fd2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Decodes dut1 frames by sampling txd in the middle of each bit period.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_on = 1'b0;
        end else begin
            if (mon_on) begin
                mk++;
                if (mk % B == B / 2) mbits[mk / B] = txd1;
                if (mk == 10 * B) begin
                    mon_q.push_back(mbits);
                    mon_on = 1'b0;
                end
            end
            if (|rdy1) begin
                mon_on = 1'b1;
                mk = 0;
                mbits = '0;
            end
        end
    end

    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] v);
        logic [1:0] r;
        int idx;
        r = ptr;
        for (int j = 3; j >= 0; j--) begin
            idx = (int'(ptr) + j) % 4;
            if (v[idx]) r = 2'(idx);
        end
        return r;
    endfunction

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int p;
        p = (k - 1) / B;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        return 1'b1;
    endfunction

    task automatic wait_idle1();
        @(negedge clk);
        for (int c = 0; c < 200 && busy1; c++) @(negedge clk);
        if (busy1) begin
            total++; bad++;
            $display("FAIL idle_timeout got busy=%b exp=0", busy1);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mptr1 = '0;
        mon_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1 v1 = 4'b1000; d1 = 32'h5A00_0000;
        @(posedge clk); #1 v1 = '0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b exp=1", busy1); end
        total++; if (gid1 !== 2'd3) begin bad++; $display("FAIL pre_reset_gid got=%0d exp=3", gid1); end
        #2 rst_n = 1'b0; v1 = 4'b0001;
        #1;
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        total++; if (rdy1 !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", rdy1); end
        total++; if (fd1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", fd1); end
        total++; if (gid1 !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", gid1); end
        v1 = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        mptr1 = '0;
        mon_q.delete();
    endtask

    task automatic test_single();
        logic [1:0] g;
        logic [9:0] fr;
        @(posedge clk); #1 v1 = 4'b0100; d1 = 32'h00A5_0000;
        @(negedge clk);
        g = rr_pick(mptr1, v1);
        total++; if (rdy1 !== (4'b0001 << g)) begin bad++; $display("FAIL single_ready got=%b exp=%b", rdy1, 4'b0001 << g); end
        mptr1 = g + 2'd1;
        @(posedge clk); #1 v1 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            total++; if (txd1 !== exp_bit(8'hA5, k)) begin bad++; $display("FAIL single_txd k=%0d got=%b exp=%b", k, txd1, exp_bit(8'hA5, k)); end
            total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy1); end
            total++; if (fd1 !== (k == 40)) begin bad++; $display("FAIL single_done k=%0d got=%b exp=%b", k, fd1, k == 40); end
            if (k == 1) begin
                total++; if (rdy1 !== 4'b0000) begin bad++; $display("FAIL single_ready_len got=%b exp=0000", rdy1); end
                total++; if (gid1 !== 2'd2) begin bad++; $display("FAIL single_gid got=%0d exp=2", gid1); end
            end
        end
        @(negedge clk);
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy1); end
        total++; if (fd1 !== 1'b0) begin bad++; $display("FAIL single_done_end got=%b exp=0", fd1); end
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL single_idle_txd got=%b exp=1", txd1); end
        total++; if (gid1 !== 2'd2) begin bad++; $display("FAIL single_gid_hold got=%0d exp=2", gid1); end
        fr = (mon_q.size() > 0) ? mon_q.pop_front() : 10'h000;
        total++; if (fr !== {1'b1, 8'hA5, 1'b0}) begin bad++; $display("FAIL single_frame got=%h exp=%h", fr, {1'b1, 8'hA5, 1'b0}); end
        mon_q.delete();
    endtask

    task automatic test_all_four();
        logic [1:0] g;
        logic [9:0] eq[$];
        logic [9:0] fr;
        int ngr, last;
        reset_dut();
        ngr = 0; last = 0;
        @(posedge clk); #1 v1 = 4'b1111; d1 = $urandom;
        for (int c = 0; c < 400 && ngr < 4; c++) begin
            @(negedge clk);
            if (|rdy1) begin
                g = rr_pick(mptr1, v1);
                total++; if (rdy1 !== (4'b0001 << g)) begin bad++; $display("FAIL four_ready n=%0d got=%b exp=%b", ngr, rdy1, 4'b0001 << g); end
                total++; if (rdy1 !== (4'b0001 << ngr)) begin bad++; $display("FAIL four_order n=%0d got=%b exp=%b", ngr, rdy1, 4'b0001 << ngr); end
                if (ngr > 0) begin
                    total++; if (cyc - last !== 41) begin bad++; $display("FAIL four_spacing n=%0d got=%0d exp=41", ngr, cyc - last); end
                end
                last = cyc;
                eq.push_back({1'b1, d1[g*8 +: 8], 1'b0});
                mptr1 = g + 2'd1;
                ngr++;
                @(posedge clk); #1 v1[g] = 1'b0;
                @(negedge clk);
                total++; if (gid1 !== g) begin bad++; $display("FAIL four_gid got=%0d exp=%0d", gid1, g); end
            end
        end
        if (ngr < 4) begin total++; bad++; $display("FAIL four_timeout got=%0d exp=4 grants", ngr); end
        v1 = '0;
        wait_idle1();
        total++; if (mon_q.size() !== eq.size()) begin bad++; $display("FAIL four_count got=%0d exp=%0d", mon_q.size(), eq.size()); end
        while (mon_q.size() > 0 && eq.size() > 0) begin
            fr = mon_q.pop_front();
            total++; if (fr !== eq[0]) begin bad++; $display("FAIL four_frame got=%h exp=%h", fr, eq[0]); end
            void'(eq.pop_front());
        end
        mon_q.delete();
    endtask

    task automatic test_alternate();
        logic [1:0] g, obs, prev;
        logic [1:0] seq [4];
        logic [9:0] eq[$];
        logic [9:0] fr;
        int ngr;
        seq[0] = 2'd0; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd3;
        ngr = 0; prev = 2'd1;
        mon_q.delete();
        @(posedge clk); #1 v1 = 4'b1001; d1 = $urandom;
        for (int c = 0; c < 400 && ngr < 4; c++) begin
            @(negedge clk);
            if (|rdy1) begin
                g = rr_pick(mptr1, v1);
                obs = rdy1[3] ? 2'd3 : rdy1[2] ? 2'd2 : rdy1[1] ? 2'd1 : 2'd0;
                total++; if (rdy1 !== (4'b0001 << g)) begin bad++; $display("FAIL alt_ready got=%b exp=%b", rdy1, 4'b0001 << g); end
                total++; if (obs !== seq[ngr]) begin bad++; $display("FAIL alt_order n=%0d got=%0d exp=%0d", ngr, obs, seq[ngr]); end
                if (ngr > 0) begin
                    total++; if (obs === prev) begin bad++; $display("FAIL alt_repeat got=%0d exp!=%0d", obs, prev); end
                end
                prev = obs;
                eq.push_back({1'b1, d1[g*8 +: 8], 1'b0});
                mptr1 = g + 2'd1;
                ngr++;
                @(posedge clk); #1 d1[g*8 +: 8] = 8'($urandom);
            end
        end
        if (ngr < 4) begin total++; bad++; $display("FAIL alt_timeout got=%0d exp=4 grants", ngr); end
        @(negedge clk);
        @(posedge clk); #1 v1 = '0;
        wait_idle1();
        while (mon_q.size() > 0 && eq.size() > 0) begin
            fr = mon_q.pop_front();
            total++; if (fr !== eq[0]) begin bad++; $display("FAIL alt_frame got=%h exp=%h", fr, eq[0]); end
            void'(eq.pop_front());
        end
        total++; if (eq.size() !== 0) begin bad++; $display("FAIL alt_missing got=%0d exp=0", eq.size()); end
        mon_q.delete();
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic [9:0] eq[$];
        logic [9:0] fr;
        wait_idle1();
        mon_q.delete();
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1 v1 = 4'($urandom_range(1, 15)); d1 = $urandom;
            @(negedge clk);
            g = rr_pick(mptr1, v1);
            total++; if (rdy1 !== (4'b0001 << g)) begin bad++; $display("FAIL rand_ready r=%0d got=%b exp=%b", r, rdy1, 4'b0001 << g); end
            eq.push_back({1'b1, d1[g*8 +: 8], 1'b0});
            mptr1 = g + 2'd1;
            @(posedge clk); #1 v1 = '0;
            @(negedge clk);
            total++; if (gid1 !== g) begin bad++; $display("FAIL rand_gid r=%0d got=%0d exp=%0d", r, gid1, g); end
            // Requests raised and withdrawn mid-frame must leave no trace.
            for (int n = 0; n < 5; n++) begin
                @(posedge clk); #1 v1 = 4'($urandom); d1 = $urandom;
                @(negedge clk);
                total++; if (rdy1 !== 4'b0000) begin bad++; $display("FAIL rand_busy_ready got=%b exp=0000", rdy1); end
            end
            @(posedge clk); #1 v1 = '0;
            wait_idle1();
        end
        while (mon_q.size() > 0 && eq.size() > 0) begin
            fr = mon_q.pop_front();
            total++; if (fr !== eq[0]) begin bad++; $display("FAIL rand_frame got=%h exp=%h", fr, eq[0]); end
            void'(eq.pop_front());
        end
        total++; if (eq.size() !== 0) begin bad++; $display("FAIL rand_missing got=%0d exp=0", eq.size()); end
        mon_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [1:0] g;
        logic [9:0] fr;
        int ndone;
        wait_idle1();
        mon_q.delete();
        @(posedge clk); #1 v1 = 4'b0010; d1 = 32'h0000_FF00;
        @(negedge clk);
        g = rr_pick(mptr1, v1);
        total++; if (rdy1 !== (4'b0001 << g)) begin bad++; $display("FAIL mid_ready got=%b exp=%b", rdy1, 4'b0001 << g); end
        mptr1 = g + 2'd1;
        @(posedge clk); #1 v1 = '0;
        for (int k = 1; k <= 18; k++) @(negedge clk);
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b exp=1", busy1); end
        rst_n = 1'b0;
        #1;
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL mid_txd got=%b exp=1", txd1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy1); end
        total++; if (fd1 !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", fd1); end
        mptr1 = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fd1 === 1'b1 || busy1 === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", ndone); end
        total++; if (mon_q.size() !== 0) begin bad++; $display("FAIL mid_discard got=%0d exp=0", mon_q.size()); end
        @(posedge clk); #1 v1 = 4'b1010; d1 = 32'h7700_3C00;
        @(negedge clk);
        g = rr_pick(mptr1, v1);
        total++; if (rdy1 !== 4'b0010) begin bad++; $display("FAIL mid_winner got=%b exp=0010", rdy1); end
        mptr1 = g + 2'd1;
        @(posedge clk); #1 v1 = '0;
        @(negedge clk);
        total++; if (gid1 !== 2'd1) begin bad++; $display("FAIL mid_gid got=%0d exp=1", gid1); end
        wait_idle1();
        fr = (mon_q.size() > 0) ? mon_q.pop_front() : 10'h000;
        total++; if (fr !== {1'b1, 8'h3C, 1'b0}) begin bad++; $display("FAIL mid_frame got=%h exp=%h", fr, {1'b1, 8'h3C, 1'b0}); end
        mon_q.delete();
    endtask

    task automatic test_stop2();
        @(posedge clk); #1 v2 = 4'b0001; d2 = '0;
        @(negedge clk);
        total++; if (rdy2 !== 4'b0001) begin bad++; $display("FAIL stop2_ready got=%b exp=0001", rdy2); end
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            total++; if (txd2 !== exp_bit(8'h00, k)) begin bad++; $display("FAIL stop2_txd k=%0d got=%b exp=%b", k, txd2, exp_bit(8'h00, k)); end
            total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL stop2_busy k=%0d got=%b exp=1", k, busy2); end
            total++; if (fd2 !== (k == 44)) begin bad++; $display("FAIL stop2_done k=%0d got=%b exp=%b", k, fd2, k == 44); end
            total++; if (rdy2 !== 4'b0000) begin bad++; $display("FAIL stop2_ready_busy k=%0d got=%b exp=0000", k, rdy2); end
        end
        @(negedge clk);
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL stop2_idle got=%b exp=0", busy2); end
        total++; if (rdy2 !== 4'b0001) begin bad++; $display("FAIL stop2_regrant got=%b exp=0001", rdy2); end
        @(posedge clk); #1 v2 = '0;
        @(negedge clk);
        total++; if (txd2 !== 1'b0) begin bad++; $display("FAIL stop2_second_start got=%b exp=0", txd2); end
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL stop2_second_busy got=%b exp=1", busy2); end
        for (int c = 0; c < 200 && busy2; c++) @(negedge clk);
        if (busy2) begin total++; bad++; $display("FAIL stop2_timeout got busy=%b exp=0", busy2); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_random();
        test_reset_midframe();
        test_stop2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART 8N1 transmit line among four byte-stream requesters. A round-robin arbiter grants one requester per frame. An internal bit-period counter serializes the byte: start bit, 8 data bits LSB first, then stop bit(s). It sits between on-chip producers (debug, status, echo and similar) and the board TXD pin, and replaces ad-hoc per-source baud/shift logic.

Parameters:
BAUD_DIV, 10416, clocks per bit (100 MHz / 9600); legal range 2 to 65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low.
req_valid  input  4  per-requester byte valid; bit i belongs to requester i.
req_data  input  32  requester i byte on bits [8i+7:8i].
req_ready  output  4  one-hot accept strobe, combinational.
txd  output  1  serial line, registered, idle high.
busy  output  1  high while a frame is in progress.
grant_id  output  2  index of the requester owning the current or last frame.
frame_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
Reset values (asynchronous, all take effect immediately on rst_n low):
- txd=1, busy=0, frame_done=0, grant_id=0.
- Round-robin pointer ptr=0, state=IDLE, bit counter=0, shift register=0.
- req_ready is 0 whenever state is not IDLE, and during reset.

States: IDLE, START, DATA, STOP.

IDLE:
- Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod 4.
- req_ready[winner]=1 in that same cycle; all other bits are 0.
- At that clock edge: capture req_data[winner] into the shift register, set grant_id=winner, set ptr=(winner+1) mod 4, clear the bit counter, txd<=0, busy<=1, go to START.
- No valid input: stay in IDLE, txd=1.

Requester rules:
- Data must be held stable while valid is high.
- The transfer completes in the cycle valid and ready are both high.
- Valid may be withdrawn before it is granted; no side effects.

Bit counter:
- Counts 0..BAUD_DIV-1; each bit lasts exactly BAUD_DIV clocks.
- Width is ceil(log2(BAUD_DIV)).
- Wraps to 0 at the end of each bit.

START: after BAUD_DIV clocks, txd<=shift[0] and go to DATA with bit index 0.

DATA:
- At the end of each bit, shift right and drive the next bit on txd.
- After bit 7 completes, txd<=1 and go to STOP.

STOP:
- Lasts STOP_BITS*BAUD_DIV clocks.
- frame_done=1 on its final clock.
- At that edge: busy<=0, go to IDLE.

Timing:
- Start-bit first clock is one clock after the accept edge.
- Frame length is (9+STOP_BITS)*BAUD_DIV clocks.
- Back-to-back frames have a minimum start-to-start spacing of (9+STOP_BITS)*BAUD_DIV+1 clocks, because IDLE always lasts at least one cycle.

Boundary conditions:
- Requests arriving during a frame wait; they are not queued beyond the held valid.
- Multiple simultaneous requests are resolved only by ptr.
- ptr advances only on a grant.
- Reset mid-frame aborts the frame: txd returns high immediately and the byte is discarded; no frame_done is issued.
- grant_id holds its value after a frame until the next grant.

Test Plan:
All scenarios use BAUD_DIV=4 unless stated.
1. Reset: assert rst_n=0 in the middle of a clock cycle -> txd=1, busy=0, req_ready=0, frame_done=0 immediately, before any clock edge.
2. Single request, req_valid=4'b0100 with byte 0xA5, STOP_BITS=1:
   -> req_ready=4'b0100 for exactly 1 cycle, grant_id=2.
   -> txd low for 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high for 4 clocks.
   -> frame_done pulses on clock 40 after the accept edge; busy is high for exactly 40 clocks.
3. Four requesters valid together after reset, each holding valid until its own ready -> grants in order 0,1,2,3; start-to-start spacing of 41 clocks.
4. Requesters 0 and 3 continuously valid, new data after each ready -> grant sequence 0,3,0,3; no requester is granted twice in a row.
5. Requester 1 granted with 0xFF; assert rst_n low during data bit 3, then release -> txd=1 and busy=0 immediately, no frame_done. A new request from requester 1 then wins with ptr=0 and its frame is correct.
6. STOP_BITS=2, byte 0x00, requester 0 held valid for two frames -> stop bit high for 8 clocks, frame of 44 clocks, second start bit begins 45 clocks after the first.
